quad_enc_gen: RTL and testbench
===============================

Name: quad_enc_gen

Overview:
- Generates quadrature A/B signals from a commanded target position. Used for bench and loopback tests of the encoder input path.
- Drives enc_a/enc_b into the encoder debounce/counter chain, so the firmware position, period and frequency readouts can be checked against known motion with no real encoder attached.
- Each emitted A/B edge is one x4 count. Edge spacing is a programmable number of sysclk cycles.

Parameters:
- POS_WIDTH, 24, width of position counter and target.
- RESET_POS, 24'h800000, reset value of position and target (half-scale, matching the encoder preload default).
- MIN_PERIOD, 4, minimum sysclk cycles between edges; smaller period requests are clamped to this.

Ports:
- sysclk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- enable  in  1  1 = motion allowed; 0 = forced idle
- period  in  16  sysclk cycles per edge (live input)
- target_wen  in  1  one-cycle pulse: load target from target_in
- target_in  in  POS_WIDTH  commanded position
- set_pos  in  1  one-cycle pulse: load cur_pos from pos_init
- pos_init  in  POS_WIDTH  position preload value
- enc_a  out  1  quadrature channel A (registered)
- enc_b  out  1  quadrature channel B (registered)
- cur_pos  out  POS_WIDTH  position corresponding to current A/B state
- dir  out  1  direction of last edge: 1 = forward
- busy  out  1  1 while in MOVE state

Behaviour:
- Clock and reset: one clock, sysclk. Reset is asynchronous, active-low, on port reset.
- Reset values: enc_a=0, enc_b=0, cur_pos=RESET_POS, target_r=RESET_POS, dir=1, busy=0, timer=0, state=IDLE.
- Effective period: eff = max(period, MIN_PERIOD).
- Phase sequence (A,B):
  - Forward: 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  - Backward: the reverse order.
  - Exactly one of A/B changes per edge; never both.
- target_wen: target_r <= target_in at the clock edge. No other effect.
- States:
  - IDLE: busy=0, timer=0. If enable=1 and cur_pos != target_r, go to MOVE with timer=0.
  - MOVE: busy=1. timer increments each cycle. When timer >= eff-1:
    - Take one step: phase advances; cur_pos +/-1; dir updated; timer <= 0.
    - Direction is decided at the step: forward if target_r > cur_pos (unsigned), backward if target_r < cur_pos.
    - If the new cur_pos equals target_r, go to IDLE.
    - If target_r == cur_pos at the step instant (target rewritten mid-step), no step occurs; go to IDLE.
- Latency: with target_wen at cycle 0 from IDLE, the first A/B change is visible at cycle eff+2. Later edges follow every eff cycles.
- The timer uses >= so that lowering period mid-count takes effect immediately, with no rollover wait.
- Target rewritten during MOVE: timer is not reset. The new direction applies at the next step.
- set_pos:
  - cur_pos <= pos_init; state <= IDLE; timer <= 0.
  - enc_a/enc_b hold their values (phase preserved).
  - set_pos takes priority over a step in the same cycle.
  - Simultaneous target_wen and set_pos: both loads occur.
- enable=0: state <= IDLE, timer <= 0. Outputs and cur_pos hold. Motion resumes from the current phase when enable returns to 1.
- Wrap-around: motion follows unsigned comparison, so cur_pos never crosses 0 <-> 2^POS_WIDTH-1. There is no shortest-path logic.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). A/B may jump to 00; this is permitted.

Test Plan:
- Reset: assert reset mid-MOVE -> enc_a=0, enc_b=0, cur_pos=800000, busy=0 on the same cycle.
- Forward move: period=4, target_wen with 800003 -> A/B sequence 10, 11, 01 at cycles 6, 10, 14. cur_pos ends at 800003, dir=1, busy drops at cycle 14.
- Backward move plus clamp: period=1, target 7FFFFE from 800000 -> two edges spaced 4 cycles apart. A/B 01 then 11. cur_pos=7FFFFE, dir=0.
- Target reversal mid-move: target 800010 at period 8; after 3 edges write target 800000 -> next edge is backward. cur_pos returns to 800000, and no A/B transition changes both bits.
- set_pos collision: set_pos with 123456 asserted on the step cycle -> no A/B change, cur_pos=123456, state IDLE. Motion then restarts toward target_r.
- enable drop: enable=0 mid-move for 20 cycles -> A/B frozen, busy=0. Re-enable -> next edge eff+1 cycles later, same direction.

Source files
------------

// File: rtl/quad_enc_gen.sv
// Quadrature A/B generator: steps a x4 position toward a commanded target,
// emitting one A/B edge per count with programmable sysclk spacing.
module quad_enc_gen #(
    parameter int unsigned           POS_WIDTH  = 24,
    parameter logic [POS_WIDTH-1:0]  RESET_POS  = {1'b1, {(POS_WIDTH-1){1'b0}}},
    parameter int unsigned           MIN_PERIOD = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [15:0]          period,
    input  logic                 target_wen,
    input  logic [POS_WIDTH-1:0] target_in,
    input  logic                 set_pos,
    input  logic [POS_WIDTH-1:0] pos_init,
    output logic                 enc_a,
    output logic                 enc_b,
    output logic [POS_WIDTH-1:0] cur_pos,
    output logic                 dir,
    output logic                 busy
);

    typedef enum logic {
        ST_IDLE,
        ST_MOVE
    } state_t;

    state_t                 state_q;
    logic [15:0]            timer_q;
    logic [POS_WIDTH-1:0]   pos_q;
    logic [POS_WIDTH-1:0]   target_q;
    logic                   a_q;
    logic                   b_q;
    logic                   dir_q;
    logic                   busy_q;

    logic [15:0]            eff_period;
    logic                   timer_done;
    logic                   fwd;
    logic [POS_WIDTH-1:0]   pos_d;

    // Clamped edge spacing, step-due flag and direction/next position for a step.
    always_comb begin
        eff_period = (period < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : period;
        timer_done = (timer_q >= (eff_period - 16'd1));
        fwd        = (target_q > pos_q);
        pos_d      = fwd ? (pos_q + 1'b1) : (pos_q - 1'b1);
    end

    // Motion FSM; set_pos outranks enable, which outranks stepping.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            pos_q    <= RESET_POS;
            target_q <= RESET_POS;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            dir_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            if (target_wen) begin
                target_q <= target_in;
            end

            if (set_pos) begin
                pos_q   <= pos_init;
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                timer_q <= '0;
            end else if (!enable) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                timer_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        timer_q <= '0;
                        if (pos_q != target_q) begin
                            state_q <= ST_MOVE;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_MOVE: begin
                        if (timer_done) begin
                            timer_q <= '0;
                            if (target_q == pos_q) begin
                                // target rewritten onto the current position: stop without stepping
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                dir_q <= fwd;
                                pos_q <= pos_d;
                                // forward 00->10->11->01, backward is the reverse
                                if (fwd) begin
                                    a_q <= ~b_q;
                                    b_q <= a_q;
                                end else begin
                                    a_q <= b_q;
                                    b_q <= ~a_q;
                                end
                                if (pos_d == target_q) begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end
                        end else begin
                            timer_q <= timer_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

    assign enc_a   = a_q;
    assign enc_b   = b_q;
    assign cur_pos = pos_q;
    assign dir     = dir_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed bench for quad_enc_gen. Inputs change and outputs are sampled on the
// falling edge; "edge k" is the k-th rising edge after a stimulus is first driven.
module tb_quad_enc_gen;

    logic        sysclk;
    logic        reset;
    logic        enable;
    logic [15:0] period;
    logic        target_wen;
    logic [23:0] target_in;
    logic        set_pos;
    logic [23:0] pos_init;
    logic        enc_a;
    logic        enc_b;
    logic [23:0] cur_pos;
    logic        dir;
    logic        busy;

    int vectors;
    int miscompares;

    quad_enc_gen #(
        .POS_WIDTH (24),
        .RESET_POS (24'h800000),
        .MIN_PERIOD(4)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .enable    (enable),
        .period    (period),
        .target_wen(target_wen),
        .target_in (target_in),
        .set_pos   (set_pos),
        .pos_init  (pos_init),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .cur_pos   (cur_pos),
        .dir       (dir),
        .busy      (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic do_reset();
        reset      = 1'b0;
        enable     = 1'b1;
        period     = 16'd4;
        target_wen = 1'b0;
        target_in  = '0;
        set_pos    = 1'b0;
        pos_init   = '0;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({enc_a, enc_b} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ab got=%b exp=00", {enc_a, enc_b});
        end
        vectors++;
        if (cur_pos !== 24'h800000) begin
            miscompares++;
            $display("FAIL reset_pos got=%h exp=800000", cur_pos);
        end
        vectors++;
        if ({dir, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_dir_busy got=%b exp=10", {dir, busy});
        end
    endtask

    task automatic test_forward();
        int          ck[6]  = '{5, 6, 9, 10, 13, 14};
        logic [1:0]  cab[6] = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01};
        logic        cbusy[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        period     = 16'd4;
        target_in  = 24'h800003;
        target_wen = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge sysclk);
            target_wen = 1'b0;
            if (k == 1) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fwd_busy_e1 got=%b exp=0", busy);
                end
            end
            for (int j = 0; j < 6; j++) begin
                if (k == ck[j]) begin
                    vectors++;
                    if ({enc_a, enc_b, busy} !== {cab[j], cbusy[j]}) begin
                        miscompares++;
                        $display("FAIL fwd_ab_busy_e%0d got=%b exp=%b", k, {enc_a, enc_b, busy}, {cab[j], cbusy[j]});
                    end
                end
            end
        end
        vectors++;
        if ({cur_pos, dir} !== {24'h800003, 1'b1}) begin
            miscompares++;
            $display("FAIL fwd_final got=%h/%b exp=800003/1", cur_pos, dir);
        end
    endtask

    task automatic test_backward_clamp();
        do_reset();
        period     = 16'd1;
        target_in  = 24'h7FFFFE;
        target_wen = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge sysclk);
            target_wen = 1'b0;
            if (k == 5 || k == 9) begin
                vectors++;
                if ({enc_a, enc_b} !== ((k == 5) ? 2'b00 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL bwd_hold_e%0d got=%b", k, {enc_a, enc_b});
                end
            end
            if (k == 6) begin
                vectors++;
                if ({enc_a, enc_b, cur_pos} !== {2'b01, 24'h7FFFFF}) begin
                    miscompares++;
                    $display("FAIL bwd_e6 got=%b/%h exp=01/7fffff", {enc_a, enc_b}, cur_pos);
                end
            end
            if (k == 10) begin
                vectors++;
                if ({enc_a, enc_b, busy} !== 3'b110) begin
                    miscompares++;
                    $display("FAIL bwd_e10 got=%b exp=110", {enc_a, enc_b, busy});
                end
            end
        end
        vectors++;
        if ({cur_pos, dir} !== {24'h7FFFFE, 1'b0}) begin
            miscompares++;
            $display("FAIL bwd_final got=%h/%b exp=7ffffe/0", cur_pos, dir);
        end
    endtask

    task automatic test_reversal();
        logic [1:0] prev;
        int         both_changes;
        do_reset();
        both_changes = 0;
        prev         = {enc_a, enc_b};
        period       = 16'd8;
        target_in    = 24'h800010;
        target_wen   = 1'b1;
        for (int k = 1; k <= 56; k++) begin
            @(negedge sysclk);
            target_wen = 1'b0;
            if ((prev ^ {enc_a, enc_b}) == 2'b11) both_changes++;
            prev = {enc_a, enc_b};
            if (k == 26) begin
                vectors++;
                if ({enc_a, enc_b, cur_pos} !== {2'b01, 24'h800003}) begin
                    miscompares++;
                    $display("FAIL rev_e26 got=%b/%h exp=01/800003", {enc_a, enc_b}, cur_pos);
                end
                target_in  = 24'h800000;
                target_wen = 1'b1;
            end
            if (k == 33) begin
                vectors++;
                if ({enc_a, enc_b, dir} !== 3'b011) begin
                    miscompares++;
                    $display("FAIL rev_e33 got=%b exp=011", {enc_a, enc_b, dir});
                end
            end
            if (k == 34) begin
                vectors++;
                if ({enc_a, enc_b, dir, cur_pos} !== {3'b110, 24'h800002}) begin
                    miscompares++;
                    $display("FAIL rev_e34 got=%b/%h exp=110/800002", {enc_a, enc_b, dir}, cur_pos);
                end
            end
            if (k == 50) begin
                vectors++;
                if ({enc_a, enc_b, busy, cur_pos} !== {3'b000, 24'h800000}) begin
                    miscompares++;
                    $display("FAIL rev_e50 got=%b/%h exp=000/800000", {enc_a, enc_b, busy}, cur_pos);
                end
            end
        end
        vectors++;
        if (both_changes !== 0) begin
            miscompares++;
            $display("FAIL rev_both_bits got=%0d exp=0", both_changes);
        end
    endtask

    task automatic test_set_pos();
        do_reset();
        period     = 16'd4;
        target_in  = 24'h800003;
        target_wen = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge sysclk);
            target_wen = 1'b0;
            if (k == 9) begin
                pos_init = 24'h123456;
                set_pos  = 1'b1;
            end
            if (k == 10) begin
                set_pos = 1'b0;
                vectors++;
                if ({enc_a, enc_b, busy, cur_pos} !== {3'b100, 24'h123456}) begin
                    miscompares++;
                    $display("FAIL setpos_e10 got=%b/%h exp=100/123456", {enc_a, enc_b, busy}, cur_pos);
                end
            end
            if (k == 14) begin
                vectors++;
                if ({enc_a, enc_b, busy} !== 3'b101) begin
                    miscompares++;
                    $display("FAIL setpos_e14 got=%b exp=101", {enc_a, enc_b, busy});
                end
            end
            if (k == 15) begin
                vectors++;
                if ({enc_a, enc_b, dir, cur_pos} !== {3'b111, 24'h123457}) begin
                    miscompares++;
                    $display("FAIL setpos_e15 got=%b/%h exp=111/123457", {enc_a, enc_b, dir}, cur_pos);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        period     = 16'd4;
        target_in  = 24'h800010;
        target_wen = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge sysclk);
            target_wen = 1'b0;
            if (k == 11) enable = 1'b0;
            if (k == 20 || k == 31) begin
                vectors++;
                if ({enc_a, enc_b, busy, cur_pos} !== {3'b110, 24'h800002}) begin
                    miscompares++;
                    $display("FAIL endrop_frozen_e%0d got=%b/%h exp=110/800002", k, {enc_a, enc_b, busy}, cur_pos);
                end
                if (k == 31) enable = 1'b1;
            end
            if (k == 35) begin
                vectors++;
                if ({enc_a, enc_b, busy} !== 3'b111) begin
                    miscompares++;
                    $display("FAIL endrop_e35 got=%b exp=111", {enc_a, enc_b, busy});
                end
            end
            if (k == 36) begin
                vectors++;
                if ({enc_a, enc_b, dir, cur_pos} !== {3'b011, 24'h800003}) begin
                    miscompares++;
                    $display("FAIL endrop_e36 got=%b/%h exp=011/800003", {enc_a, enc_b, dir}, cur_pos);
                end
            end
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        period     = 16'd4;
        target_in  = 24'h800003;
        target_wen = 1'b1;
        repeat (11) begin
            @(negedge sysclk);
            target_wen = 1'b0;
        end
        vectors++;
        if ({enc_a, enc_b, busy} !== 3'b111) begin
            miscompares++;
            $display("FAIL rstmid_pre got=%b exp=111", {enc_a, enc_b, busy});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({enc_a, enc_b, busy, dir, cur_pos} !== {4'b0001, 24'h800000}) begin
            miscompares++;
            $display("FAIL rstmid_async got=%b/%h exp=0001/800000", {enc_a, enc_b, busy, dir}, cur_pos);
        end
        @(negedge sysclk);
        reset = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_forward();
        test_backward_clamp();
        test_reversal();
        test_set_pos();
        test_enable_drop();
        test_reset_mid_move();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
